imem_loader: RTL

Writer-side counterpart of the synchronous instruction ROM. It accepts a byte stream over a valid/ready handshake, assembles little-endian words, and drives the memory write port that fills instruction memory. The core is held in reset through `cpu_hold` until the image is fully written. It sits between the host/debug byte link and the instruction memory of the single-cycle processor.

---
 rtl/imem_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader that assembles little-endian words and fills instruction memory.
// The core is kept in reset through cpu_hold until the whole image has been written.
module imem_loader #(
  parameter int unsigned Width     = 32,
  parameter int unsigned Depth     = 32,
  parameter int unsigned AddrWidth = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [Width-1:0]     mem_wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err,
  output logic [AddrWidth:0]   words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [1:0]         byte_cnt;
  logic [Width-1:0]   length;
  logic [Width-9:0]   shift;
  logic [Width-1:0]   word_val;
  logic [AddrWidth:0] count_inc;
  logic               accept;
  logic               restart;
  logic               last_byte;
  logic               last_word;

  // Outputs that are pure decodes of the registered state
  assign in_ready = (state == S_HEADER) || (state == S_DATA);
  assign cpu_hold = (state != S_DONE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERROR);

  assign accept    = in_valid && in_ready;
  assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign last_byte = (byte_cnt == 2'd3);
  // Newest byte lands on top so the first byte received ends up in bits [7:0]
  assign word_val  = {in_data, shift};
  assign count_inc = words_loaded + (AddrWidth+1)'(1);
  assign last_word = (Width'(count_inc) == length);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_HEADER;
      end
      S_HEADER: begin
        if (accept && last_byte) begin
          if (word_val == '0)                 state_next = S_DONE;
          else if (word_val > Width'(Depth))  state_next = S_ERROR;
          else                                state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && last_byte && last_word) state_next = S_FLUSH;
      end
      S_FLUSH:  state_next = S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Byte assembly, header capture and the registered memory write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt     <= 2'd0;
      length       <= '0;
      shift        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        byte_cnt     <= 2'd0;
        length       <= '0;
        shift        <= '0;
        words_loaded <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= word_val[Width-1:8];
        if (last_byte && (state == S_HEADER)) begin
          length <= word_val;
        end
        if (last_byte && (state == S_DATA)) begin
          mem_we       <= 1'b1;
          mem_addr     <= words_loaded[AddrWidth-1:0];
          mem_wdata    <= word_val;
          words_loaded <= count_inc;
        end
      end
    end
  end

endmodule
